// File: rtl/crc32_pkg.sv
// Shared constants and the response record for the CRC32 request arbiter.
// CRC32_GEN uses zero init, no reflection and no final XOR.
package crc32_pkg;

    localparam logic [31:0] GEN_POLY           = 32'h814141AB;
    localparam int          CRC_WIDTH          = 32;
    localparam int          DEFAULT_DATA_WIDTH = 512;
    localparam int          MAX_ID_WIDTH       = 4;

    typedef struct packed {
        logic [MAX_ID_WIDTH-1:0] id;
        logic [CRC_WIDTH-1:0]    crc;
        logic                    err;
    } rsp_t;

endpackage

// File: rtl/CRC32_GEN.sv
// Combinational CRC32 over one block, MSB first, zero initial value.
// The unrolled shift loop collapses into a pure XOR network.
module CRC32_GEN
    import crc32_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CRC_WIDTH-1:0]  crc_o
);

    logic [CRC_WIDTH-1:0] w_acc;

    always_comb begin
        w_acc = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (w_acc[CRC_WIDTH-1] ^ data_i[i]) begin
                w_acc = {w_acc[CRC_WIDTH-2:0], 1'b0} ^ GEN_POLY;
            end else begin
                w_acc = {w_acc[CRC_WIDTH-2:0], 1'b0};
            end
        end
        crc_o = w_acc;
    end

endmodule

// File: rtl/crc_rr_picker.sv
// Round-robin pick: first valid index after ptr_i, wrapping modulo NUM_REQ.
// Purely combinational; the caller owns the pointer register.
module crc_rr_picker #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  valid_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  grant_oh_o,
    output logic [ID_WIDTH-1:0] grant_idx_o,
    output logic                any_o
);

    // One spare bit so ptr + offset never overflows before the wrap.
    logic [ID_WIDTH:0] w_sum;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        w_sum       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, ptr_i} + (ID_WIDTH+1)'(k);
            if (w_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_WIDTH+1)'(NUM_REQ);
            end
            if (!any_o && valid_i[w_sum[ID_WIDTH-1:0]]) begin
                any_o       = 1'b1;
                grant_idx_o = w_sum[ID_WIDTH-1:0];
            end
        end
        grant_oh_o[grant_idx_o] = any_o;
    end

endmodule

// File: rtl/crc32_req_arbiter.sv
// Round-robin front end sharing one CRC32_GEN between NUM_REQ requesters.
// Two-stage pipeline (s1 = request, s2 = response) sustaining one block per cycle.
module crc32_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int CRC_WIDTH  = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]                   req_chk_i,
    input  logic [NUM_REQ-1:0][CRC_WIDTH-1:0]    req_crc_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]           rsp_id_o,
    output logic [CRC_WIDTH-1:0]                 rsp_crc_o,
    output logic                                 rsp_err_o,
    output logic [15:0]                          err_cnt_o
);
    import crc32_pkg::*;

    localparam int ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    w_grant_oh;
    logic [ID_WIDTH-1:0]   w_grant_idx;
    logic                  w_grant_any;
    logic                  w_s2_free;
    logic                  w_s1_adv;
    logic                  w_take;
    logic [CRC_WIDTH-1:0]  w_crc;
    logic                  w_err;
    logic                  w_unused_id;

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic [ID_WIDTH-1:0]   r_s1_id;
    logic                  r_s1_chk;
    logic [CRC_WIDTH-1:0]  r_s1_exp;
    logic                  r_s2_valid;
    rsp_t                  r_s2;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [15:0]           r_err_cnt;

    crc_rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .valid_i     (req_valid_i),
        .ptr_i       (r_ptr),
        .grant_oh_o  (w_grant_oh),
        .grant_idx_o (w_grant_idx),
        .any_o       (w_grant_any)
    );

    CRC32_GEN #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_crc (
        .data_i (r_s1_data),
        .crc_o  (w_crc)
    );

    // s2 may drain and s1 refill on the same edge, so no bubble under full load.
    assign w_s2_free = !r_s2_valid || rsp_ready_i;
    assign w_s1_adv  = !r_s1_valid || w_s2_free;
    assign w_take    = w_s1_adv && w_grant_any;
    assign w_err     = r_s1_chk && (w_crc != r_s1_exp);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready_o[gi] = rst_n && w_take && w_grant_oh[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_chk   <= 1'b0;
            r_s1_exp   <= '0;
            r_ptr      <= ID_WIDTH'(NUM_REQ - 1);
        end else if (w_s1_adv) begin
            r_s1_valid <= w_grant_any;
            if (w_grant_any) begin
                r_s1_id  <= w_grant_idx;
                r_s1_chk <= req_chk_i[w_grant_idx];
                r_s1_exp <= req_crc_i[w_grant_idx];
                r_ptr    <= w_grant_idx;
            end
        end
    end

    // Wide payload needs no reset: it is only observed through r_s1_valid.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_s1_data <= req_data_i[w_grant_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (r_s1_valid && w_s2_free) begin
            r_s2_valid <= 1'b1;
            r_s2.id    <= MAX_ID_WIDTH'(r_s1_id);
            r_s2.crc   <= w_crc;
            r_s2.err   <= w_err;
        end else if (rsp_ready_i) begin
            r_s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (r_s2_valid && rsp_ready_i && r_s2.err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign rsp_valid_o = r_s2_valid;
    assign rsp_id_o    = r_s2.id[ID_WIDTH-1:0];
    assign rsp_crc_o   = r_s2.crc;
    assign rsp_err_o   = r_s2.err;
    assign err_cnt_o   = r_err_cnt;
    assign w_unused_id = ^r_s2.id;

endmodule

// File: tb/tb_crc32_req_arbiter.sv
// Self-checking bench: a queue-level model of the arbiter/pipeline is compared
// against the DUT on every falling edge, plus directed literal expectations.
module tb_crc32_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 512;
    localparam int CW = 32;
    localparam int IW = 2;
    localparam logic [CW-1:0] POLY = 32'h814141AB;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [N-1:0]             req_valid_i;
    logic [N-1:0][DW-1:0]     req_data_i;
    logic [N-1:0]             req_chk_i;
    logic [N-1:0][CW-1:0]     req_crc_i;
    logic [N-1:0]             req_ready_o;
    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [IW-1:0]            rsp_id_o;
    logic [CW-1:0]            rsp_crc_o;
    logic                     rsp_err_o;
    logic [15:0]              err_cnt_o;

    always #5 clk = ~clk;

    crc32_req_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CRC_WIDTH(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_chk_i   (req_chk_i),
        .req_crc_i   (req_crc_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_crc_o   (rsp_crc_o),
        .rsp_err_o   (rsp_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    typedef struct { logic [DW-1:0] data; logic chk; logic [CW-1:0] exp; } blk_t;
    typedef struct { int id; logic [CW-1:0] crc; logic err; bit out; } item_t;

    blk_t         feed [N][$];
    item_t        mq [$];
    int           grant_log [$];
    int           m_ptr = N - 1;
    int           m_err_cnt = 0;
    int           delivered = 0;
    int           checks = 0;
    int           failures = 0;
    logic [N-1:0] acc_mask = '0;
    bit           gaps = 1'b0;
    bit           quiet = 1'b0;

    // Reference CRC by long division of d(x)*x^32 by G(x) (augmented form).
    function automatic logic [CW-1:0] crc_ref(input logic [DW-1:0] d);
        logic [CW-1:0] r;
        logic          top;
        r = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            top = r[CW-1];
            r = {r[CW-2:0], d[i]};
            if (top) r = r ^ POLY;
        end
        for (int i = 0; i < CW; i++) begin
            top = r[CW-1];
            r = {r[CW-2:0], 1'b0};
            if (top) r = r ^ POLY;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_blk();
        logic [DW-1:0] v;
        for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic bit feeds_empty();
        for (int i = 0; i < N; i++) if (feed[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model + compare, evaluated mid-cycle while inputs are stable.
    int           g;
    bit           hv;
    bit           room;
    logic [N-1:0] exp_ready;
    logic [CW-1:0] acc_crc;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
            check("reset_req_ready", 64'(req_ready_o), 64'd0);
            check("reset_err_cnt", 64'(err_cnt_o), 64'd0);
            mq.delete();
            m_ptr = N - 1;
            m_err_cnt = 0;
            acc_mask = '0;
        end else begin
            hv = (mq.size() > 0) && mq[0].out;
            check("rsp_valid", 64'(rsp_valid_o), 64'(hv));
            if (hv) begin
                check("rsp_id", 64'(rsp_id_o), 64'(mq[0].id));
                check("rsp_crc", 64'(rsp_crc_o), 64'(mq[0].crc));
                check("rsp_err", 64'(rsp_err_o), 64'(mq[0].err));
            end
            check("err_cnt", 64'(err_cnt_o), 64'(m_err_cnt));
            g = -1;
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && req_valid_i[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            room = !(mq.size() == 2 && !rsp_ready_i);
            exp_ready = '0;
            if (g >= 0 && room) exp_ready[g] = 1'b1;
            check("req_ready", 64'(req_ready_o), 64'(exp_ready));
            if (hv && rsp_ready_i) begin
                if (!quiet) $display("rsp id=%0d crc=%08h err=%0b", mq[0].id, mq[0].crc, mq[0].err);
                delivered++;
                if (mq[0].err && m_err_cnt < 65535) m_err_cnt++;
                mq.delete(0);
            end
            if (mq.size() > 0 && !mq[0].out && (!hv || rsp_ready_i)) mq[0].out = 1'b1;
            if (exp_ready != '0) begin
                acc_crc = crc_ref(req_data_i[g]);
                mq.push_back('{id: g, crc: acc_crc,
                               err: req_chk_i[g] && (acc_crc != req_crc_i[g]), out: 1'b0});
                m_ptr = g;
                grant_log.push_back(g);
            end
            acc_mask = req_valid_i & req_ready_o;
        end
    end

    task automatic push(input int r, input logic [DW-1:0] d, input logic c, input logic [CW-1:0] e);
        blk_t b;
        b.data = d;
        b.chk  = c;
        b.exp  = e;
        feed[r].push_back(b);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (feed[i].size() > 0 && (req_valid_i[i] || !gaps || $urandom_range(0, 2) != 0)) begin
                req_valid_i[i] = 1'b1;
                req_data_i[i]  = feed[i][0].data;
                req_chk_i[i]   = feed[i][0].chk;
                req_crc_i[i]   = feed[i][0].exp;
            end else begin
                req_valid_i[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) begin
                if (feed[i].size() > 0) feed[i].delete(0);
                req_valid_i[i] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c <= budget; c++) begin
            idle = feeds_empty() && (mq.size() == 0) && !rsp_valid_o;
            if (idle) break;
            step();
        end
        check(name, 64'(idle), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) feed[i].delete();
        req_valid_i = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic run_one(input int r, input logic [DW-1:0] d, input logic c, input logic [CW-1:0] e,
                           input logic [CW-1:0] want_crc, input logic want_err, input string name);
        bit seen;
        seen = 1'b0;
        push(r, d, c, e);
        drive();
        for (int k = 0; k < 8; k++) begin
            step();
            if (rsp_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({name, "_id"}, 64'(rsp_id_o), 64'(r));
            check({name, "_crc"}, 64'(rsp_crc_o), 64'(want_crc));
            check({name, "_err"}, 64'(rsp_err_o), 64'(want_err));
        end
        wait_idle(20, {name, "_idle"});
    endtask

    logic [IW-1:0] cap_id;
    logic [CW-1:0] cap_crc;
    logic          cap_err;
    int            g0;
    int            d0;
    logic [DW-1:0] blk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid_i = '0;
        req_data_i  = '0;
        req_chk_i   = '0;
        req_crc_i   = '0;
        rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req_valid_i = '1;
        #1;
        check("t0_ready_in_reset", 64'(req_ready_o), 64'd0);
        check("t0_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("t0_rsp_crc", 64'(rsp_crc_o), 64'd0);
        req_valid_i = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: zero block, two-edge latency
        push(0, '0, 1'b0, '0);
        drive();
        step();
        check("t1_not_yet", 64'(rsp_valid_o), 64'd0);
        step();
        check("t1_valid", 64'(rsp_valid_o), 64'd1);
        check("t1_id", 64'(rsp_id_o), 64'd0);
        check("t1_crc", 64'(rsp_crc_o), 64'd0);
        check("t1_err", 64'(rsp_err_o), 64'd0);
        wait_idle(20, "t1_idle");

        // 2: generate/check on data=1, plus data=2
        run_one(1, 512'h1, 1'b0, 32'h0, 32'h814141AB, 1'b0, "t2_gen");
        run_one(1, 512'h1, 1'b1, 32'h814141AB, 32'h814141AB, 1'b0, "t2_chk_ok");
        run_one(1, 512'h1, 1'b1, 32'h814141AA, 32'h814141AB, 1'b1, "t2_chk_bad");
        check("t2_err_cnt", 64'(err_cnt_o), 64'd1);
        run_one(2, 512'h2, 1'b0, 32'h0, 32'h83C3C2FD, 1'b0, "t2_gen2");

        // 3: all requesters continuously valid from reset
        do_reset();
        grant_log.delete();
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < 3; k++) begin
                blk = rand_blk();
                push(r, blk, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? crc_ref(blk) : $urandom());
            end
        end
        drive();
        wait_idle(100, "t3_idle");
        check("t3_grant_count", 64'(grant_log.size()), 64'd12);
        for (int k = 0; k < 12 && k < grant_log.size(); k++) begin
            check($sformatf("t3_grant_%0d", k), 64'(grant_log[k]), 64'(k % N));
        end

        // 4: backpressure with both stages full
        g0 = grant_log.size();
        d0 = delivered;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < 6; k++) push(r, rand_blk(), 1'b0, '0);
        end
        drive();
        repeat (3) step();
        rsp_ready_i = 1'b0;
        #1;
        cap_id  = rsp_id_o;
        cap_crc = rsp_crc_o;
        cap_err = rsp_err_o;
        check("t4_ready_low", 64'(req_ready_o), 64'd0);
        repeat (5) begin
            step();
            check("t4_hold_valid", 64'(rsp_valid_o), 64'd1);
            check("t4_hold_id", 64'(rsp_id_o), 64'(cap_id));
            check("t4_hold_crc", 64'(rsp_crc_o), 64'(cap_crc));
            check("t4_hold_err", 64'(rsp_err_o), 64'(cap_err));
            check("t4_hold_ready", 64'(req_ready_o), 64'd0);
        end
        check("t4_in_flight", 64'((grant_log.size() - g0) - (delivered - d0)), 64'd2);
        rsp_ready_i = 1'b1;
        wait_idle(200, "t4_idle");
        check("t4_accepted", 64'(grant_log.size() - g0), 64'd24);
        check("t4_delivered", 64'(delivered - d0), 64'd24);

        // 5: reset with both stages full
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < 3; k++) push(r, rand_blk(), 1'b1, $urandom());
        end
        drive();
        repeat (3) step();
        rsp_ready_i = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("t5_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("t5_req_ready", 64'(req_ready_o), 64'd0);
        check("t5_rsp_id", 64'(rsp_id_o), 64'd0);
        check("t5_rsp_crc", 64'(rsp_crc_o), 64'd0);
        check("t5_rsp_err", 64'(rsp_err_o), 64'd0);
        check("t5_err_cnt", 64'(err_cnt_o), 64'd0);
        for (int i = 0; i < N; i++) feed[i].delete();
        req_valid_i = '0;
        repeat (2) step();
        push(2, 512'h5, 1'b0, '0);
        push(3, 512'h6, 1'b0, '0);
        drive();
        #1;
        check("t5_ready_held_low", 64'(req_ready_o), 64'd0);
        rsp_ready_i = 1'b1;
        grant_log.delete();
        step();
        rst_n = 1'b1;
        wait_idle(50, "t5_idle");
        check("t5_grant_count", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() > 0) check("t5_first_grant", 64'(grant_log[0]), 64'd2);

        // random traffic with gaps and backpressure, model-scoreboarded
        gaps = 1'b1;
        d0 = delivered;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < 40; k++) begin
                blk = rand_blk();
                push(r, blk, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? crc_ref(blk) : $urandom());
            end
        end
        drive();
        for (int c = 0; c < 4000; c++) begin
            if (feeds_empty() && mq.size() == 0 && !rsp_valid_o) break;
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        rsp_ready_i = 1'b1;
        gaps = 1'b0;
        wait_idle(50, "t6_rand_idle");
        check("t6_rand_delivered", 64'(delivered - d0), 64'd160);

        // 6: error counter saturation
        do_reset();
        quiet = 1'b1;
        d0 = delivered;
        for (int k = 0; k < 65540; k++) push(0, '0, 1'b1, 32'h1);
        drive();
        wait_idle(70000, "t6_sat_idle");
        quiet = 1'b0;
        check("t6_sat_delivered", 64'(delivered - d0), 64'd65540);
        check("t6_err_cnt_sat", 64'(err_cnt_o), 64'h000000000000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
